// File: rtl/uart8_pkg.sv
// Shared definitions for the buffered UART echo: the state encoding used by
// both the receive and transmit FSMs, plus the oversampling constants.
package uart8_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uartState_t;

  localparam int OVERSAMPLE   = 16;
  localparam int SAMPLE_POINT = 8;

endpackage

// File: rtl/uart8_sync_fifo.sv
// Single-clock FIFO holding received characters until the transmitter takes
// them. A push into a full FIFO is dropped unless a pop happens in the same
// cycle, in which case both proceed and the count is unchanged.
module uart8_sync_fifo
  import uart8_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wrData,
  output logic [WIDTH-1:0]       rdData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doWrite;
  logic             doRead;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign doWrite = push && (!full || pop);
  assign doRead  = pop && !empty;
  assign rdData  = mem[rdPtr];

  // Storage array; written only when the push is accepted.
  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= wrData;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
      case ({doWrite, doRead})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart8_echo_fifo.sv
// Buffered UART echo: 16x oversampled receiver, FIFO, and transmitter that
// resends good characters in arrival order. Framing errors and overflow are
// flagged. Define UART_PARITY_EN to add a parity bit to both directions.
module uart8_echo_fifo
  import uart8_pkg::*;
#(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
`ifdef UART_PARITY_EN
  parameter bit PARITY_ODD = 1'b0,
`endif
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic                        tx,
  input  logic                        rxEn,
  input  logic                        txEn,
  output logic                        rxBusy,
  output logic                        rxErr,
  output logic                        txBusy,
  output logic                        txDone,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount,
  output logic                        overflow
);

  localparam int DIV  = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDXW = $clog2(DATA_BITS);

  logic [DIVW-1:0]      tickCnt;
  logic                 tick;
  logic                 rxMeta, rxSync;

  uartState_t           rxState, rxStateNext;
  logic [3:0]           rxSub, rxSubNext;
  logic [IDXW-1:0]      rxBit, rxBitNext;
  logic [DATA_BITS-1:0] rxShift, rxShiftNext;
  logic                 rxPush;
  logic                 rxParOk;

  uartState_t           txState, txStateNext;
  logic [4:0]           txSub, txSubNext;
  logic [IDXW-1:0]      txBit, txBitNext;
  logic [DATA_BITS-1:0] txShift, txShiftNext;
  logic                 txPop;
  logic                 txLeaving;
  logic                 txParBit;

  logic [DATA_BITS-1:0] fifoRdData;
  logic                 fifoFull, fifoEmpty;

`ifdef UART_PARITY_EN
  logic rxPar, rxParNext;
  logic txPar, txParNext;
  assign rxParOk  = (rxPar == ((^rxShift) ^ PARITY_ODD));
  assign txParBit = txPar;
`else
  assign rxParOk  = 1'b1;
  assign txParBit = 1'b1;
`endif

  assign tick   = (tickCnt == DIVW'(DIV - 1));
  assign rxBusy = (rxState != IDLE);
  assign txBusy = (txState != IDLE);

  // Free-running divider producing one oversample tick every DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tickCnt <= '0;
    else if (tick) tickCnt <= '0;
    else           tickCnt <= tickCnt + 1'b1;
  end

  // Two-flop synchroniser; resets to idle-high so reset never fakes a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxState <= IDLE;
      rxSub   <= '0;
      rxBit   <= '0;
      rxShift <= '0;
`ifdef UART_PARITY_EN
      rxPar   <= 1'b0;
`endif
    end else begin
      rxState <= rxStateNext;
      rxSub   <= rxSubNext;
      rxBit   <= rxBitNext;
      rxShift <= rxShiftNext;
`ifdef UART_PARITY_EN
      rxPar   <= rxParNext;
`endif
    end
  end

  // Receiver next state: start validated at mid-bit, then one sample per bit.
  always_comb begin
    rxStateNext = rxState;
    rxSubNext   = rxSub;
    rxBitNext   = rxBit;
    rxShiftNext = rxShift;
    rxPush      = 1'b0;
    rxErr       = 1'b0;
`ifdef UART_PARITY_EN
    rxParNext   = rxPar;
`endif
    if (!rxEn) begin
      rxStateNext = IDLE;
    end else begin
      case (rxState)
        IDLE: begin
          if (!rxSync) begin
            rxStateNext = START;
            rxSubNext   = '0;
          end
        end
        START: begin
          if (tick) begin
            if (rxSub == 4'(SAMPLE_POINT - 1)) begin
              rxSubNext = '0;
              rxBitNext = '0;
              if (rxSync) rxStateNext = IDLE;
              else        rxStateNext = DATA;
            end else begin
              rxSubNext = rxSub + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (rxSub == 4'(OVERSAMPLE - 1)) begin
              rxSubNext   = '0;
              rxShiftNext = {rxSync, rxShift[DATA_BITS-1:1]};
              rxBitNext   = rxBit + 1'b1;
              if (rxBit == IDXW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                rxStateNext = PARITY;
`else
                rxStateNext = STOP;
`endif
              end
            end else begin
              rxSubNext = rxSub + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (rxSub == 4'(OVERSAMPLE - 1)) begin
              rxSubNext   = '0;
              rxParNext   = rxSync;
              rxStateNext = STOP;
            end else begin
              rxSubNext = rxSub + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (rxSub == 4'(OVERSAMPLE - 1)) begin
              rxSubNext   = '0;
              rxStateNext = IDLE;
              if (rxSync && rxParOk) rxPush = 1'b1;
              else                   rxErr  = 1'b1;
            end else begin
              rxSubNext = rxSub + 1'b1;
            end
          end
        end
        default: rxStateNext = IDLE;
      endcase
    end
  end

  uart8_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (rxPush),
    .pop    (txPop),
    .wrData (rxShift),
    .rdData (fifoRdData),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  // Sticky overflow: a good character arrived with no room for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             overflow <= 1'b0;
    else if (rxPush && fifoFull && !txPop)  overflow <= 1'b1;
  end

  // Transmitter state register and registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txState <= IDLE;
      txSub   <= '0;
      txBit   <= '0;
      txShift <= '0;
      txDone  <= 1'b0;
`ifdef UART_PARITY_EN
      txPar   <= 1'b0;
`endif
    end else begin
      txState <= txStateNext;
      txSub   <= txSubNext;
      txBit   <= txBitNext;
      txShift <= txShiftNext;
      txDone  <= txLeaving;
`ifdef UART_PARITY_EN
      txPar   <= txParNext;
`endif
    end
  end

  // Transmitter next state: frames start on a tick so every bit is 16 ticks.
  always_comb begin
    txStateNext = txState;
    txSubNext   = txSub;
    txBitNext   = txBit;
    txShiftNext = txShift;
    txPop       = 1'b0;
    txLeaving   = 1'b0;
`ifdef UART_PARITY_EN
    txParNext   = txPar;
`endif
    case (txState)
      IDLE: begin
        if (txEn && !fifoEmpty && tick) begin
          txPop       = 1'b1;
          txShiftNext = fifoRdData;
          txSubNext   = '0;
          txStateNext = START;
`ifdef UART_PARITY_EN
          txParNext   = (^fifoRdData) ^ PARITY_ODD;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (txSub == 5'(OVERSAMPLE - 1)) begin
            txSubNext   = '0;
            txBitNext   = '0;
            txStateNext = DATA;
          end else begin
            txSubNext = txSub + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (txSub == 5'(OVERSAMPLE - 1)) begin
            txSubNext   = '0;
            txShiftNext = txShift >> 1;
            txBitNext   = txBit + 1'b1;
            if (txBit == IDXW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              txStateNext = PARITY;
`else
              txStateNext = STOP;
`endif
            end
          end else begin
            txSubNext = txSub + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (txSub == 5'(OVERSAMPLE - 1)) begin
            txSubNext   = '0;
            txStateNext = STOP;
          end else begin
            txSubNext = txSub + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (txSub == 5'(STOP_BITS * OVERSAMPLE - 1)) begin
            txSubNext   = '0;
            txStateNext = IDLE;
            txLeaving   = 1'b1;
          end else begin
            txSubNext = txSub + 1'b1;
          end
        end
      end
      default: txStateNext = IDLE;
    endcase
  end

  // Line level follows the transmit state; idle and stop are both high.
  always_comb begin
    tx = 1'b1;
    case (txState)
      START:   tx = 1'b0;
      DATA:    tx = txShift[0];
      PARITY:  tx = txParBit;
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart8_echo_fifo.sv
// Bench for uart8_echo_fifo: a serial driver issues frames and queues the
// characters that should be echoed; a line monitor decodes tx and checks each
// frame against the queue. Honours UART_PARITY_EN when defined.
module tb_uart8_echo_fifo;

  localparam int CLK_RATE = 1600000;
  localparam int BAUD     = 10000;
  localparam int DBITS    = 8;
  localparam int DEPTH    = 16;
  localparam int BIT_CLKS = 160;
`ifdef UART_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rxEn = 1'b1;
  logic       txEn = 1'b1;
  logic       tx, rxBusy, rxErr, txBusy, txDone, overflow;
  logic [4:0] fifoCount;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] expQ[$];
  int  heldCount = 0;
  int  expErrCount = 0;
  logic expOverflow = 1'b0;

  int rxErrCount = 0;
  int txDoneCount = 0;
  int framesSeen = 0;
  int busyRun = 0;
  int lastBusyLen = 0;
  int latCnt = 0;
  int lastLatency = 0;
  logic latArmed = 1'b0;

  logic [7:0] monData;
  logic [7:0] monExp;

  always #5 clk = ~clk;

  uart8_echo_fifo #(
    .CLOCK_RATE (CLK_RATE),
    .BAUD_RATE  (BAUD),
    .DATA_BITS  (DBITS),
    .STOP_BITS  (1),
`ifdef UART_PARITY_EN
    .PARITY_ODD (1'b0),
`endif
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .tx        (tx),
    .rxEn      (rxEn),
    .txEn      (txEn),
    .rxBusy    (rxBusy),
    .rxErr     (rxErr),
    .txBusy    (txBusy),
    .txDone    (txDone),
    .fifoCount (fifoCount),
    .overflow  (overflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    compared++;
    if (actual < lo || actual > hi) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Drives one frame on rx and records what the echo should contain.
  task automatic applyStimulus(input logic [7:0] data, input bit goodStop, input bit badParity, input int gap);
    bit good;
    good = goodStop && !badParity;
    if (good) begin
      if (!txEn && heldCount >= DEPTH) expOverflow = 1'b1;
      else begin
        expQ.push_back(data);
        if (!txEn) heldCount++;
      end
    end else begin
      expErrCount++;
    end
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < DBITS; i++) begin
      rx = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = (^data) ^ badParity;
    repeat (BIT_CLKS) @(negedge clk);
`endif
    if (goodStop) begin
      rx = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
    end else begin
      // Low long enough to be sampled as a bad stop, released before a
      // re-detected start could be confirmed.
      rx = 1'b0;
      repeat (100) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLKS - 100) @(negedge clk);
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 40000; c++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !txBusy) break;
    end
    checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  // Event counters and rx-busy / echo-latency measurement.
  always @(negedge clk) begin
    if (rxErr)  rxErrCount  <= rxErrCount + 1;
    if (txDone) txDoneCount <= txDoneCount + 1;
    if (rxBusy) begin
      busyRun <= busyRun + 1;
    end else if (busyRun != 0) begin
      lastBusyLen <= busyRun;
      busyRun     <= 0;
      latCnt      <= 1;
      latArmed    <= 1'b1;
    end else if (latArmed) begin
      if (!tx) begin
        lastLatency <= latCnt;
        latArmed    <= 1'b0;
      end else begin
        latCnt <= latCnt + 1;
      end
    end
  end

  // Line monitor: decodes each tx frame and compares against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        repeat (BIT_CLKS/2 - 1) @(negedge clk);
        checkOutput("tx_start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < DBITS; i++) begin
          repeat (BIT_CLKS) @(negedge clk);
          monData[i] = tx;
        end
`ifdef UART_PARITY_EN
        repeat (BIT_CLKS) @(negedge clk);
        checkOutput("tx_parity_bit", 32'(tx), 32'(^monData));
`endif
        repeat (BIT_CLKS) @(negedge clk);
        checkOutput("tx_stop_bit", 32'(tx), 32'd1);
        framesSeen++;
        checkRange("tx_frame_was_expected", expQ.size(), 1, 1000);
        if (expQ.size() > 0) begin
          monExp = expQ.pop_front();
          checkOutput("tx_data", 32'(monData), 32'(monExp));
        end
      end
    end
  end

  initial begin
    int baseFrames;
    int baseDone;
    logic [7:0] d;

    // Reset held with rx toggling.
    rst_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx = i[0];
    end
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_rxBusy", 32'(rxBusy), 32'd0);
    checkOutput("rst_rxErr", 32'(rxErr), 32'd0);
    checkOutput("rst_txBusy", 32'(txBusy), 32'd0);
    checkOutput("rst_txDone", 32'(txDone), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_fifoCount", 32'(fifoCount), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    checkOutput("idle_tx", 32'(tx), 32'd1);
    checkOutput("idle_rxBusy", 32'(rxBusy), 32'd0);
    checkOutput("idle_txBusy", 32'(txBusy), 32'd0);
    checkOutput("idle_fifoCount", 32'(fifoCount), 32'd0);

    // Single 0xA5 frame.
    $display("[TB] single frame 0xA5");
    baseDone = txDoneCount;
    applyStimulus(8'hA5, 1'b1, 1'b0, 0);
    waitDrain();
    checkRange("rxBusy_length", lastBusyLen, 1505 + PBITS*BIT_CLKS, 1525 + PBITS*BIT_CLKS);
    checkRange("echo_latency", lastLatency, 1, 12);
    checkOutput("single_txDone_pulses", 32'(txDoneCount - baseDone), 32'd1);
    checkOutput("single_fifoCount", 32'(fifoCount), 32'd0);

    // Short glitch on the line.
    $display("[TB] 50-clk glitch");
    baseFrames = framesSeen;
    rx = 1'b0;
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    checkOutput("glitch_rxErr", 32'(rxErrCount), 32'(expErrCount));
    checkOutput("glitch_fifoCount", 32'(fifoCount), 32'd0);
    checkOutput("glitch_no_tx", 32'(framesSeen - baseFrames), 32'd0);
    checkOutput("glitch_rxBusy", 32'(rxBusy), 32'd0);

    // Framing error.
    $display("[TB] framing error 0x3C");
    applyStimulus(8'h3C, 1'b0, 1'b0, 2000);
    checkOutput("frame_err_rxErr", 32'(rxErrCount), 32'(expErrCount));
    checkOutput("frame_err_fifoCount", 32'(fifoCount), 32'd0);
    checkOutput("frame_err_no_tx", 32'(framesSeen - baseFrames), 32'd0);

    // Randomised frames, some with bad stop bits.
    $display("[TB] random frames");
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom_range(0, 255));
      applyStimulus(d, ($urandom_range(0, 4) != 0), 1'b0, int'($urandom_range(0, 100)));
    end
    waitDrain();
    checkOutput("random_rxErr", 32'(rxErrCount), 32'(expErrCount));
    checkOutput("random_overflow", 32'(overflow), 32'(expOverflow));
    checkOutput("random_fifoCount", 32'(fifoCount), 32'd0);

    // Overflow with the transmitter held off.
    $display("[TB] overflow");
    txEn = 1'b0;
    heldCount = 0;
    for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b1, 1'b0, 0);
    repeat (20) @(negedge clk);
    checkOutput("ovf_fifoCount", 32'(fifoCount), 32'(heldCount));
    checkOutput("ovf_flag", 32'(overflow), 32'(expOverflow));
    baseFrames = framesSeen;
    txEn = 1'b1;
    heldCount = 0;
    waitDrain();
    checkOutput("ovf_frames_echoed", 32'(framesSeen - baseFrames), 32'd16);
    checkOutput("ovf_fifoCount_after", 32'(fifoCount), 32'd0);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

`ifdef UART_PARITY_EN
    $display("[TB] parity");
    baseFrames = framesSeen;
    applyStimulus(8'h07, 1'b1, 1'b0, 100);
    applyStimulus(8'h07, 1'b1, 1'b1, 100);
    waitDrain();
    checkOutput("parity_echoed", 32'(framesSeen - baseFrames), 32'd1);
    checkOutput("parity_rxErr", 32'(rxErrCount), 32'(expErrCount));
`endif

    repeat (50) @(negedge clk);
    checkOutput("final_rxErr_count", 32'(rxErrCount), 32'(expErrCount));
    checkOutput("final_txDone_count", 32'(txDoneCount), 32'(framesSeen));
    checkOutput("final_tx_idle", 32'(tx), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
